sdram_arb: RTL

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_pkg.sv | 22 ++
 rtl/sdram_arb_if.sv | 50 +++++
 rtl/sdram_arb_rr.sv | 33 +++
 rtl/sdram_arb.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared widths, defaults and types for the SDRAM arbiter
package sdram_arb_pkg;

  localparam int ADDR_W      = 24;
  localparam int LEN_W       = 10;
  localparam int TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_GRANT = 3'd2,
    ST_XFER  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/sdram_arb_if.sv
// rtl/sdram_arb_if.sv - client and SDRAM controller signal bundle for the arbiter
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic              c0_req;
  logic              c0_wr;
  logic [ADDR_W-1:0] c0_addr;
  logic [LEN_W-1:0]  c0_len;
  logic              c0_ack;
  logic              c0_done;

  logic              c1_req;
  logic              c1_wr;
  logic [ADDR_W-1:0] c1_addr;
  logic [LEN_W-1:0]  c1_len;
  logic              c1_ack;
  logic              c1_done;

  logic              sdram_init_done;
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [ADDR_W-1:0] sys_wraddr;
  logic [ADDR_W-1:0] sys_rdaddr;
  logic [LEN_W-1:0]  sdwr_byte;
  logic [LEN_W-1:0]  sdrd_byte;

  logic              busy;
  logic              err;

  modport slave (
    input  c0_req, c0_wr, c0_addr, c0_len,
    input  c1_req, c1_wr, c1_addr, c1_len,
    input  sdram_init_done, sdram_wr_ack, sdram_rd_ack,
    output c0_ack, c0_done, c1_ack, c1_done,
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    output busy, err
  );

  modport master (
    output c0_req, c0_wr, c0_addr, c0_len,
    output c1_req, c1_wr, c1_addr, c1_len,
    output sdram_init_done, sdram_wr_ack, sdram_rd_ack,
    input  c0_ack, c0_done, c1_ack, c1_done,
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    input  busy, err
  );

endinterface

// File: rtl/sdram_arb_rr.sv
// rtl/sdram_arb_rr.sv - two-way round-robin pick with last-served register
module sdram_arb_rr (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic served_i,
  output logic valid_o,
  output logic pick_o
);

  logic last_q;

  // Reset to client 1 so that client 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= served_i;
    end
  end

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      pick_o = ~last_q;
    end else begin
      pick_o = req1_i;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - two-client SDRAM burst arbiter with grant timeout and beat checking
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic        clk,
  input logic        rst_n,
  sdram_arb_if.slave bus
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e           state_q;
  cmd_t             cmd_q;
  logic             gnt_q;
  logic             wr_req_q;
  logic             rd_req_q;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;
  logic             err_q;
  logic [LEN_W-1:0] beat_q;
  logic [TW-1:0]    tmo_q;

  cmd_t             cmd0;
  cmd_t             cmd1;
  logic             rr_valid;
  logic             rr_pick;
  logic             match_ack;

  assign cmd0 = {bus.c0_wr, bus.c0_addr, bus.c0_len};
  assign cmd1 = {bus.c1_wr, bus.c1_addr, bus.c1_len};

  sdram_arb_rr u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0_i   (bus.c0_req),
    .req1_i   (bus.c1_req),
    .upd_i    (state_q == ST_DONE && bus.sdram_init_done),
    .served_i (gnt_q),
    .valid_o  (rr_valid),
    .pick_o   (rr_pick)
  );

  // Only the ack matching the live request direction counts; the other is ignored.
  assign match_ack = cmd_q.wr ? (bus.sdram_wr_ack & wr_req_q)
                              : (bus.sdram_rd_ack & rd_req_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cmd_q    <= '0;
      gnt_q    <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      beat_q   <= '0;
      tmo_q    <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (state_q != ST_INIT && !bus.sdram_init_done) begin
        state_q  <= ST_INIT;
        wr_req_q <= 1'b0;
        rd_req_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_INIT: begin
            if (bus.sdram_init_done) state_q <= ST_IDLE;
          end
          ST_IDLE: begin
            if (rr_valid) begin
              gnt_q    <= rr_pick;
              cmd_q    <= rr_pick ? cmd1 : cmd0;
              wr_req_q <= rr_pick ? cmd1.wr : cmd0.wr;
              rd_req_q <= rr_pick ? ~cmd1.wr : ~cmd0.wr;
              beat_q   <= '0;
              tmo_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_GRANT;
            end
          end
          ST_GRANT: begin
            if (match_ack) begin
              beat_q  <= LEN_W'(1);
              state_q <= ST_XFER;
            end else if (tmo_q == TMO_LAST) begin
              wr_req_q <= 1'b0;
              rd_req_q <= 1'b0;
              err_q    <= 1'b1;
              done0_q  <= ~gnt_q;
              done1_q  <= gnt_q;
              state_q  <= ST_DONE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          ST_XFER: begin
            if (match_ack) begin
              beat_q <= beat_q + 1'b1;
            end else begin
              wr_req_q <= 1'b0;
              rd_req_q <= 1'b0;
              done0_q  <= ~gnt_q;
              done1_q  <= gnt_q;
              state_q  <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (beat_q != cmd_q.len) err_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign bus.c0_ack       = match_ack & ~gnt_q;
  assign bus.c1_ack       = match_ack & gnt_q;
  assign bus.c0_done      = done0_q;
  assign bus.c1_done      = done1_q;
  assign bus.sdram_wr_req = wr_req_q;
  assign bus.sdram_rd_req = rd_req_q;
  assign bus.sys_wraddr   = cmd_q.addr;
  assign bus.sys_rdaddr   = cmd_q.addr;
  assign bus.sdwr_byte    = cmd_q.len;
  assign bus.sdrd_byte    = cmd_q.len;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule
